// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges load and ALU results onto the single RF write port.
// Loads win; losing ALU results queue in order. A pending-write scoreboard is exported to decode.
module wb_arbiter #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              wena,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              alu_stall,
    input  logic [ADDR_W-1:0] q0addr,
    input  logic [ADDR_W-1:0] q1addr,
    output logic              q0_pend,
    output logic              q1_pend,
    output logic              ovf_err,
    output logic              waw_err
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              wena_q, wena_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ovf_q, waw_q;

    logic empty, full, pop, push_req, push, ovf_set, waw_set;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop      = !ld_valid && !empty;
    assign push_req = alu_valid && (ld_valid || !empty);
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        waw_set = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ld_valid && vld_q[i] && (mem_addr[i] == ld_addr)) waw_set = 1'b1;
        end
    end

    always_comb begin
        wena_d  = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (ld_valid) begin
            wena_d  = 1'b1;
            waddr_d = ld_addr;
            wdata_d = ld_data;
        end else if (!empty) begin
            wena_d  = 1'b1;
            waddr_d = mem_addr[rd_ptr_q];
            wdata_d = mem_data[rd_ptr_q];
        end else if (alu_valid) begin
            wena_d  = 1'b1;
            waddr_d = alu_addr;
            wdata_d = alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wena_q   <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            waw_q    <= 1'b0;
        end else begin
            wena_q  <= wena_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            if (pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (ovf_set) ovf_q <= 1'b1;
            if (waw_set) waw_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= alu_addr;
            mem_data[wr_ptr_q] <= alu_data;
        end
    end

    always_comb begin
        q0_pend = wena_q && (waddr_q == q0addr);
        q1_pend = wena_q && (waddr_q == q1addr);
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (mem_addr[i] == q0addr)) q0_pend = 1'b1;
            if (vld_q[i] && (mem_addr[i] == q1addr)) q1_pend = 1'b1;
        end
    end

    assign wena      = wena_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign alu_stall = (count_q >= CNT_W'(DEPTH - 1));
    assign ovf_err   = ovf_q;
    assign waw_err   = waw_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0;
    logic [2:0]  alu_addr = '0;
    logic [63:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic [2:0]  ld_addr = '0;
    logic [63:0] ld_data = '0;
    logic        wena;
    logic [2:0]  waddr;
    logic [63:0] wdata;
    logic        alu_stall;
    logic [2:0]  q0addr = '0;
    logic [2:0]  q1addr = '0;
    logic        q0_pend, q1_pend, ovf_err, waw_err;

    int n_checks = 0;
    int n_fail   = 0;

    wb_arbiter #(.DATA_W(64), .ADDR_W(3), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .wena      (wena),
        .waddr     (waddr),
        .wdata     (wdata),
        .alu_stall (alu_stall),
        .q0addr    (q0addr),
        .q1addr    (q1addr),
        .q0_pend   (q0_pend),
        .q1_pend   (q1_pend),
        .ovf_err   (ovf_err),
        .waw_err   (waw_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [2:0] aa, input logic [63:0] ad,
                         input logic lv, input logic [2:0] la, input logic [63:0] lda);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        ld_valid  = lv; ld_addr  = la; ld_data  = lda;
    endtask

    task automatic check_wr(input string tag, input logic [2:0] a, input logic [63:0] d);
        check({tag, ".wena"}, 64'(wena), 64'd1);
        check({tag, ".waddr"}, 64'(waddr), 64'(a));
        check({tag, ".wdata"}, wdata, d);
    endtask

    initial begin
        // Reset state
        tick();
        check("rst.wena", 64'(wena), 64'd0);
        check("rst.waddr", 64'(waddr), 64'd0);
        check("rst.wdata", wdata, 64'd0);
        check("rst.stall", 64'(alu_stall), 64'd0);
        check("rst.q0p", 64'(q0_pend), 64'd0);
        check("rst.q1p", 64'(q1_pend), 64'd0);
        check("rst.ovf", 64'(ovf_err), 64'd0);
        check("rst.waw", 64'(waw_err), 64'd0);
        rst = 1'b1;
        tick();

        // Direct bypass
        drive(1, 3'd3, 64'hA5, 0, 3'd0, 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check_wr("dir", 3'd3, 64'hA5);
        check("dir.cnt", 64'(dut.count_q), 64'd0);
        tick();
        check("dir.idle", 64'(wena), 64'd0);
        check("dir.hold", 64'(waddr), 64'd3);

        // Collision: load first, ALU queued
        q0addr = 3'd2; q1addr = 3'd1;
        drive(1, 3'd2, 64'h22, 1, 3'd1, 64'h11);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check_wr("col.c1", 3'd1, 64'h11);
        check("col.c1.q0p", 64'(q0_pend), 64'd1);
        check("col.c1.q1p", 64'(q1_pend), 64'd1);
        tick();
        check_wr("col.c2", 3'd2, 64'h22);
        check("col.c2.q0p", 64'(q0_pend), 64'd1);
        check("col.c2.q1p", 64'(q1_pend), 64'd0);
        tick();
        check("col.c3.wena", 64'(wena), 64'd0);
        check("col.c3.q0p", 64'(q0_pend), 64'd0);

        // Fill and stall under sustained loads
        q0addr = 3'd3;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(1, 3'(k), 64'h100 + 64'(k), 1, 3'd7, 64'h700 + 64'(k));
            else       drive(0, 0, 0, 1, 3'd7, 64'h700 + 64'(k));
            tick();
            check_wr("fill.ld", 3'd7, 64'h700 + 64'(k));
            check("fill.stall", 64'(alu_stall), (k >= 2) ? 64'd1 : 64'd0);
        end
        check("fill.q0p", 64'(q0_pend), 64'd1);
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_wr("fill.pop", 3'(k), 64'h100 + 64'(k));
            check("fill.stall2", 64'(alu_stall), (k == 0) ? 64'd1 : 64'd0);
        end
        tick();
        check("fill.done", 64'(wena), 64'd0);
        check("fill.ovf", 64'(ovf_err), 64'd0);

        // Overflow: fifth ALU result dropped while full with no pop
        q0addr = 3'd5;
        for (int k = 0; k < 4; k++) begin
            drive(1, 3'(k), 64'h200 + 64'(k), 1, 3'd7, 64'h0);
            tick();
        end
        check("ovf.pre", 64'(ovf_err), 64'd0);
        drive(1, 3'd5, 64'hDEAD, 1, 3'd7, 64'h0);
        tick();
        check("ovf.set", 64'(ovf_err), 64'd1);
        check("ovf.q0p", 64'(q0_pend), 64'd0);
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_wr("ovf.pop", 3'(k), 64'h200 + 64'(k));
        end
        tick();
        check("ovf.done", 64'(wena), 64'd0);
        check("ovf.sticky", 64'(ovf_err), 64'd1);

        // WAW flag: load hits an address still queued
        drive(1, 3'd6, 64'h66, 1, 3'd1, 64'h31);
        tick();
        check_wr("waw.c0", 3'd1, 64'h31);
        check("waw.pre", 64'(waw_err), 64'd0);
        drive(0, 0, 0, 1, 3'd6, 64'h77);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check_wr("waw.ld", 3'd6, 64'h77);
        check("waw.set", 64'(waw_err), 64'd1);
        tick();
        check_wr("waw.alu", 3'd6, 64'h66);
        tick();
        check("waw.done", 64'(wena), 64'd0);

        // Reset mid-stream with three queued entries
        for (int k = 0; k < 3; k++) begin
            drive(1, 3'(k), 64'h300 + 64'(k), 1, 3'd4, 64'h0);
            tick();
        end
        check("mrst.stall.pre", 64'(alu_stall), 64'd1);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mrst.wena", 64'(wena), 64'd0);
        check("mrst.cnt", 64'(dut.count_q), 64'd0);
        check("mrst.stall", 64'(alu_stall), 64'd0);
        check("mrst.ovf", 64'(ovf_err), 64'd0);
        check("mrst.waw", 64'(waw_err), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mrst.nowr", 64'(wena), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
